// File: rtl/nibble_add_sched_if.sv
// Request/result bundle for nibble_add_sched: two requesters in, one result out.
// NIBBLE_ADD_SCHED_SUB_EN adds the per-requester subtract select.
interface nibble_add_sched_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_ci;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_ci;

`ifdef NIBBLE_ADD_SCHED_SUB_EN
  logic         req0_sub;
  logic         req1_sub;
`endif

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_co;
  logic         res_id;

  modport master (
`ifdef NIBBLE_ADD_SCHED_SUB_EN
    output req0_sub, req1_sub,
`endif
    output req0_valid, req0_a, req0_b, req0_ci,
    output req1_valid, req1_a, req1_b, req1_ci,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_co, res_id,
    output res_ready
  );

  modport slave (
`ifdef NIBBLE_ADD_SCHED_SUB_EN
    input  req0_sub, req1_sub,
`endif
    input  req0_valid, req0_a, req0_b, req0_ci,
    input  req1_valid, req1_a, req1_b, req1_ci,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_co, res_id,
    input  res_ready
  );
endinterface

// File: rtl/nibble_add_sched.sv
// Two-requester round-robin adder built on a single time-shared 4-bit slice.
// Define NIBBLE_ADD_SCHED_SUB_EN to enable per-request subtraction (a + ~b + 1).
module nibble_add_sched #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  nibble_add_sched_if.slave bus
);

  localparam int unsigned W = 4 * NIBBLES;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] LastNib = 3'(NIBBLES - 1);

  logic [1:0]   state_q, state_d;
  logic         prio_q, prio_d;
  logic         id_q, id_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         carry_q, carry_d;
  logic         co_q, co_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] sum_q, sum_d;

  logic         idle;
  logic         grant;
  logic         accept;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic         sel_ci;
  logic         sel_sub;
  logic [4:0]   slice;

  assign idle = (state_q == StIdle);

  // prio_q names the requester that wins a tie; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = prio_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign bus.req0_ready = idle && bus.req0_valid && !grant;
  assign bus.req1_ready = idle && bus.req1_valid && grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  always_comb begin
    sel_a  = grant ? bus.req1_a  : bus.req0_a;
    sel_b  = grant ? bus.req1_b  : bus.req0_b;
    sel_ci = grant ? bus.req1_ci : bus.req0_ci;
`ifdef NIBBLE_ADD_SCHED_SUB_EN
    sel_sub = grant ? bus.req1_sub : bus.req0_sub;
`else
    sel_sub = 1'b0;
`endif
  end

  // The one shared slice always works on the low nibble of the shifting operands.
  assign slice = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Subtraction is folded in at capture: invert b and force carry-in.
          a_d     = sel_a;
          b_d     = sel_sub ? ~sel_b : sel_b;
          carry_d = sel_sub ? 1'b1 : sel_ci;
          id_d    = grant;
          prio_d  = !grant;
          cnt_d   = 3'd0;
          co_d    = 1'b0;
          sum_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        sum_d   = {slice[3:0], sum_q[W-1:4]};
        carry_d = slice[4];
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == LastNib) begin
          co_d    = slice[4];
          cnt_d   = 3'd0;
          state_d = StDone;
        end
      end

      StDone: begin
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= 3'd0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.res_valid = (state_q == StDone);
  assign bus.res_sum   = sum_q;
  assign bus.res_co    = co_q;
  assign bus.res_id    = id_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed plus randomized bench for nibble_add_sched against an arithmetic reference.
// Define NIBBLE_ADD_SCHED_SUB_EN to also exercise subtraction.
module tb_nibble_add_sched;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference state: tie-break owner and expected result of the op in flight.
  logic         prio = 1'b0;
  logic [W-1:0] exp_sum;
  logic         exp_co;
  logic         exp_id;

  nibble_add_sched_if #(.NIBBLES(NIB)) bus ();

  nibble_add_sched #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic sub);
    logic [W:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    return r;
  endfunction

  // Presents a request set, checks the grant, and returns just after the accept edge.
  task automatic issue(input logic v0, input logic v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic ci0, input logic ci1,
                       input logic sub0, input logic sub1,
                       input bit drop, input bit keep);
    logic       eg;
    logic       esub;
    logic [W:0] r;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_a = a0;  bus.req0_b = b0;  bus.req0_ci = ci0;
    bus.req1_a = a1;  bus.req1_b = b1;  bus.req1_ci = ci1;
`ifdef NIBBLE_ADD_SCHED_SUB_EN
    bus.req0_sub = sub0;
    bus.req1_sub = sub1;
`endif
    #1;
    eg = (v0 && v1) ? prio : v1;
    chk("ready0", 32'(bus.req0_ready), 32'(v0 && !eg));
    chk("ready1", 32'(bus.req1_ready), 32'(v1 && eg));
    if (drop && v0 && v1) begin
      if (eg) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
      eg = !eg;
      #1;
      chk("drop_ready0", 32'(bus.req0_ready), 32'(!eg));
      chk("drop_ready1", 32'(bus.req1_ready), 32'(eg));
    end
`ifdef NIBBLE_ADD_SCHED_SUB_EN
    esub = eg ? sub1 : sub0;
`else
    esub = 1'b0;
`endif
    r = eg ? model(a1, b1, ci1, esub) : model(a0, b0, ci0, esub);
    exp_sum = r[W-1:0];
    exp_co  = r[W];
    exp_id  = eg;
    @(posedge clk);
    #1;
    prio = !eg;
    if (!keep) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    // Disturb operands after capture; the result must not follow.
    bus.req0_a = W'($urandom);  bus.req0_b = W'($urandom);  bus.req0_ci = 1'($urandom);
    bus.req1_a = W'($urandom);  bus.req1_b = W'($urandom);  bus.req1_ci = 1'($urandom);
  endtask

  // Waits for the result, checks latency and value, optionally stalls, then retires it.
  task automatic collect(input int stall);
    int lat;
    lat = 0;
    bus.res_ready = 1'b0;
    while (!bus.res_valid && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
      chk("busy_readies", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    end
    chk("latency", 32'(lat), 32'(NIB));
    chk("res_sum", 32'(bus.res_sum), 32'(exp_sum));
    chk("res_co", 32'(bus.res_co), 32'(exp_co));
    chk("res_id", 32'(bus.res_id), 32'(exp_id));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #2;
      chk("stall_hold", {13'd0, bus.res_valid, bus.res_co, bus.res_id, bus.res_sum},
          {13'd0, 1'b1, exp_co, exp_id, exp_sum});
      chk("stall_readies", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("exit_valid", 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    logic v0, v1;
    logic s0, s1;
    bus.req0_valid = 1'b0;  bus.req1_valid = 1'b0;
    bus.req0_a = '0;  bus.req0_b = '0;  bus.req0_ci = 1'b0;
    bus.req1_a = '0;  bus.req1_b = '0;  bus.req1_ci = 1'b0;
`ifdef NIBBLE_ADD_SCHED_SUB_EN
    bus.req0_sub = 1'b0;
    bus.req1_sub = 1'b0;
`endif
    bus.res_ready = 1'b0;

    #12;
    chk("reset_outputs", {12'd0, bus.res_valid, bus.res_co, bus.res_id, bus.res_sum,
                          bus.req0_ready, bus.req1_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First accept straight out of reset.
    issue(1, 0, 16'h1234, 16'h0FFF, '0, '0, 0, 0, 0, 0, 0, 0);
    collect(0);

    // Lone req1 with full wrap, then a long consumer stall.
    issue(0, 1, '0, '0, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0, 0);
    collect(10);

    // Both requesters held valid: strict alternation starting with req0.
    for (int k = 0; k < 4; k++) begin
      issue(1, 1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            1'($urandom), 1'($urandom), 0, 0, 0, 1);
      chk("rr_order", 32'(exp_id), 32'(k % 2));
      collect(0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Granted requester withdraws before the edge; the other takes over.
    issue(1, 1, 16'h0F0F, 16'h0101, 16'h7000, 16'h9000, 1, 0, 0, 0, 1, 0);
    collect(1);

    // Reset during the second RUN cycle discards the operation.
    issue(0, 1, '0, '0, 16'h1234, 16'h1111, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset", {12'd0, bus.res_valid, bus.res_co, bus.res_id, bus.res_sum,
                         bus.req0_ready, bus.req1_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prio = 1'b0;
    issue(1, 1, 16'h0001, 16'h0001, 16'h4444, 16'h4444, 0, 0, 0, 0, 0, 0);
    collect(0);

    // Randomized operations, request patterns and stalls.
    for (int k = 0; k < 16; k++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      s0 = 1'b0;
      s1 = 1'b0;
`ifdef NIBBLE_ADD_SCHED_SUB_EN
      s0 = 1'($urandom);
      s1 = 1'($urandom);
`endif
      issue(v0, v1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            1'($urandom), 1'($urandom), s0, s1, 1'($urandom), 1'($urandom));
      collect(int'($urandom_range(0, 3)));
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

`ifdef NIBBLE_ADD_SCHED_SUB_EN
    issue(1, 0, 16'h0005, 16'h0007, '0, '0, 1, 0, 1, 0, 0, 0);
    chk("sub_model_sum", 32'(exp_sum), 32'h0000FFFE);
    collect(0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
